// File: rtl/ts_pkg.sv
// Shared MPEG-2 TS definitions: lock-state encoding and stream constants,
// reused by the per-channel front end, the channel mux and the main control.
package ts_pkg;

  localparam int          TS_PKT_LEN      = 188;
  localparam logic [7:0]  TS_SYNC_BYTE    = 8'h47;
  localparam logic [12:0] TS_NULL_PID     = 13'h1FFF;
  localparam int          TS_LOCK_COUNT   = 3;
  localparam int          TS_UNLOCK_COUNT = 3;
  localparam logic [12:0] TS_CC_PID       = 13'h0100;

  typedef enum logic [1:0] {
    TS_HUNT   = 2'd0,
    TS_VERIFY = 2'd1,
    TS_LOCKED = 2'd2
  } ts_state_e;

endpackage

// File: rtl/ts_header_check.sv
// TS header checker: captures TEI and PID from bytes 1-2 and checks the
// continuity counter of one PID at byte 3, raising a one-byte hdr_err strobe.
module ts_header_check
  import ts_pkg::*;
#(
  parameter logic [12:0] CC_PID = TS_CC_PID
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid,
  input  logic [7:0] byte_pos,
  input  logic [7:0] ts_data,
  input  logic       check_en,
  input  logic       cc_clear,
  output logic       hdr_err
);

  logic       tei_q;
  logic [4:0] pid_hi_q;
  logic       pid_match_q;
  logic       cc_valid_q;
  logic [3:0] last_cc_q;

  logic       at_byte1;
  logic       at_byte2;
  logic       at_byte3;
  logic [3:0] cc;
  logic [3:0] cc_next;
  logic       cc_chk;
  logic       cc_err;

  assign at_byte1 = byte_valid && check_en && (byte_pos == 8'd1);
  assign at_byte2 = byte_valid && check_en && (byte_pos == 8'd2);
  assign at_byte3 = byte_valid && check_en && (byte_pos == 8'd3);
  assign cc       = ts_data[3:0];
  assign cc_next  = last_cc_q + 4'd1;
  // Only packets carrying payload (AFC 01/11) advance the continuity counter.
  assign cc_chk   = pid_match_q && ts_data[4];
  assign cc_err   = cc_chk && cc_valid_q && (cc != cc_next) && (cc != last_cc_q);
  assign hdr_err  = at_byte3 && (tei_q || cc_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tei_q       <= 1'b0;
      pid_hi_q    <= '0;
      pid_match_q <= 1'b0;
      cc_valid_q  <= 1'b0;
      last_cc_q   <= '0;
    end else begin
      if (at_byte1) begin
        tei_q    <= ts_data[7];
        pid_hi_q <= ts_data[4:0];
      end
      if (at_byte2) begin
        pid_match_q <= ({pid_hi_q, ts_data} == CC_PID);
      end
      if (cc_clear) begin
        cc_valid_q <= 1'b0;
      end else if (at_byte3 && cc_chk) begin
        cc_valid_q <= 1'b1;
        last_cc_q  <= cc;
      end
    end
  end

endmodule

// File: rtl/ts_packet_loss_counter.sv
// Per-channel TS front end: 188-byte sync acquisition FSM, byte position
// counter and saturating packet-loss/error counter.
module ts_packet_loss_counter
  import ts_pkg::*;
#(
  parameter int          PKT_LEN      = TS_PKT_LEN,
  parameter logic [7:0]  SYNC_BYTE    = TS_SYNC_BYTE,
  parameter int          LOCK_COUNT   = TS_LOCK_COUNT,
  parameter int          UNLOCK_COUNT = TS_UNLOCK_COUNT,
  parameter logic [12:0] CC_PID       = TS_CC_PID
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ts_data,
  input  logic       ts_valid,
  input  logic       clear_count,
  output logic       sync,
  output logic [7:0] err_count,
  output logic       pkt_start,
  output logic [1:0] lock_state
);

  localparam logic [7:0] LAST_POS = 8'(PKT_LEN - 1);
  localparam logic [3:0] LOCK_N   = 4'(LOCK_COUNT);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_COUNT);

  ts_state_e  state_q, state_d;
  logic [7:0] pos_q, pos_d;
  logic [3:0] good_q, good_d;
  logic [3:0] miss_q, miss_d;
  logic       hdr_en_q, hdr_en_d;
  logic       pkt_start_d;
  logic       miss_err;
  logic       cc_clear;
  logic       hdr_err;
  logic       is_sync;

  assign is_sync = (ts_data == SYNC_BYTE);

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    good_d      = good_q;
    miss_d      = miss_q;
    hdr_en_d    = hdr_en_q;
    pkt_start_d = 1'b0;
    miss_err    = 1'b0;
    cc_clear    = 1'b0;
    if (ts_valid) begin
      pos_d = (pos_q == LAST_POS) ? 8'd0 : pos_q + 8'd1;
      unique case (state_q)
        TS_HUNT: begin
          pos_d = 8'd0;
          if (is_sync) begin
            state_d = TS_VERIFY;
            good_d  = 4'd1;
            pos_d   = 8'd1;
          end
        end
        TS_VERIFY: begin
          if (pos_q == 8'd0) begin
            if (!is_sync) begin
              state_d = TS_HUNT;
              pos_d   = 8'd0;
            end else if (good_q + 4'd1 == LOCK_N) begin
              state_d  = TS_LOCKED;
              miss_d   = 4'd0;
              cc_clear = 1'b1;
            end else begin
              good_d = good_q + 4'd1;
            end
          end
        end
        TS_LOCKED: begin
          if (pos_q == 8'd0) begin
            if (is_sync) begin
              miss_d      = 4'd0;
              pkt_start_d = 1'b1;
              hdr_en_d    = 1'b1;
            end else begin
              // A missing sync byte voids this packet's header checks.
              hdr_en_d = 1'b0;
              miss_err = 1'b1;
              miss_d   = miss_q + 4'd1;
              if (miss_q + 4'd1 == UNLOCK_N) begin
                state_d = TS_HUNT;
                pos_d   = 8'd0;
              end
            end
          end
        end
        default: begin
          state_d  = TS_HUNT;
          pos_d    = 8'd0;
          hdr_en_d = 1'b0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TS_HUNT;
      pos_q     <= '0;
      good_q    <= '0;
      miss_q    <= '0;
      hdr_en_q  <= 1'b0;
      sync      <= 1'b0;
      pkt_start <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      good_q    <= good_d;
      miss_q    <= miss_d;
      hdr_en_q  <= hdr_en_d;
      sync      <= (state_d == TS_LOCKED);
      pkt_start <= pkt_start_d;
    end
  end

  // Clear wins over a coincident increment; the count never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear_count) begin
      err_count <= '0;
    end else if ((miss_err || hdr_err) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

  assign lock_state = state_q;

  ts_header_check #(
    .CC_PID (CC_PID)
  ) u_header_check (
    .clk        (clk),
    .rst        (rst),
    .byte_valid (ts_valid),
    .byte_pos   (pos_q),
    .ts_data    (ts_data),
    .check_en   (hdr_en_q),
    .cc_clear   (cc_clear),
    .hdr_err    (hdr_err)
  );

endmodule

// File: tb/tb_ts_packet_loss_counter.sv
// Self-checking bench for ts_packet_loss_counter: a table of whole packets
// with hand-computed counts/states, plus reset, saturation and clear sequences.
module tb_ts_packet_loss_counter;

  logic       clk;
  logic       rst;
  logic [7:0] ts_data;
  logic       ts_valid;
  logic       clear_count;
  logic       sync;
  logic [7:0] err_count;
  logic       pkt_start;
  logic [1:0] lock_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt;
  bit gap_mode = 1'b0;

  typedef struct {
    logic [7:0]  sb;
    logic        tei;
    logic [12:0] pid;
    logic [1:0]  afc;
    logic [3:0]  cc;
    int          exp_err;
    int          exp_state;
    int          exp_sync;
  } vec_t;

  localparam int NVEC = 31;
  vec_t vecs [NVEC];

  ts_packet_loss_counter dut (
    .clk         (clk),
    .rst         (rst),
    .ts_data     (ts_data),
    .ts_valid    (ts_valid),
    .clear_count (clear_count),
    .sync        (sync),
    .err_count   (err_count),
    .pkt_start   (pkt_start),
    .lock_state  (lock_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] sb, input logic tei, input logic [12:0] pid,
                              input logic [1:0] afc, input logic [3:0] cc,
                              input int e, input int s, input int y);
    vec_t v;
    v.sb = sb; v.tei = tei; v.pid = pid; v.afc = afc; v.cc = cc;
    v.exp_err = e; v.exp_state = s; v.exp_sync = y;
    return v;
  endfunction

  task automatic sample_pulse();
    if (pkt_start === 1'b1) pulse_cnt++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic clr);
    if (gap_mode && ($urandom_range(0, 1) == 1)) begin
      ts_valid = 1'b0;
      @(posedge clk); #1;
      sample_pulse();
    end
    ts_data     = b;
    ts_valid    = 1'b1;
    clear_count = clr;
    @(posedge clk); #1;
    ts_valid    = 1'b0;
    clear_count = 1'b0;
    sample_pulse();
  endtask

  task automatic send_pkt(input logic [7:0] sb, input logic tei, input logic [12:0] pid,
                          input logic [1:0] afc, input logic [3:0] cc, input int clr_pos);
    logic [7:0] b;
    for (int p = 0; p < 188; p++) begin
      case (p)
        0:       b = sb;
        1:       b = {tei, 2'b00, pid[12:8]};
        2:       b = pid[7:0];
        3:       b = {2'b00, afc, cc};
        default: b = 8'hFF;
      endcase
      send_byte(b, p == clr_pos);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_table(input string tag);
    pulse_cnt = 0;
    for (int i = 0; i < NVEC; i++) begin
      send_pkt(vecs[i].sb, vecs[i].tei, vecs[i].pid, vecs[i].afc, vecs[i].cc, -1);
      check($sformatf("%s[%0d] err_count", tag, i), 32'(err_count), vecs[i].exp_err);
      check($sformatf("%s[%0d] lock_state", tag, i), 32'(lock_state), vecs[i].exp_state);
      check($sformatf("%s[%0d] sync", tag, i), 32'(sync), vecs[i].exp_sync);
    end
    check($sformatf("%s pkt_start pulses", tag), pulse_cnt, 19);
  endtask

  initial begin
    // Clean lock on PID 0x100 with CC wrapping 15->0, then CC/TEI/sync-loss cases.
    for (int i = 0; i < 10; i++)
      vecs[i] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'((10 + i) % 16), 0,
                   (i < 2) ? 1 : 2, (i < 2) ? 0 : 1);
    vecs[10] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd4,  0, 2, 1);
    vecs[11] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd5,  0, 2, 1);
    vecs[12] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd5,  0, 2, 1);
    vecs[13] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd7,  1, 2, 1);
    vecs[14] = mk(8'h47, 1'b0, 13'h200, 2'b01, 4'd12, 1, 2, 1);
    vecs[15] = mk(8'h47, 1'b0, 13'h100, 2'b10, 4'd0,  1, 2, 1);
    vecs[16] = mk(8'h47, 1'b0, 13'h100, 2'b11, 4'd8,  1, 2, 1);
    vecs[17] = mk(8'h47, 1'b1, 13'h100, 2'b01, 4'd12, 2, 2, 1);
    vecs[18] = mk(8'h47, 1'b1, 13'h200, 2'b01, 4'd0,  3, 2, 1);
    vecs[19] = mk(8'h00, 1'b1, 13'h100, 2'b01, 4'd0,  4, 2, 1);
    vecs[20] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd13, 4, 2, 1);
    vecs[21] = mk(8'h00, 1'b0, 13'h200, 2'b01, 4'd0,  5, 2, 1);
    vecs[22] = mk(8'h00, 1'b0, 13'h200, 2'b01, 4'd0,  6, 2, 1);
    vecs[23] = mk(8'h00, 1'b0, 13'h200, 2'b01, 4'd0,  7, 0, 0);
    vecs[24] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd0,  7, 1, 0);
    vecs[25] = mk(8'h00, 1'b0, 13'h100, 2'b01, 4'd0,  7, 0, 0);
    vecs[26] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd0,  7, 1, 0);
    vecs[27] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd0,  7, 1, 0);
    vecs[28] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd0,  7, 2, 1);
    vecs[29] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd5,  7, 2, 1);
    vecs[30] = mk(8'h47, 1'b0, 13'h100, 2'b01, 4'd6,  7, 2, 1);

    rst = 1'b1; ts_data = '0; ts_valid = 1'b0; clear_count = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sync", 32'(sync), 0);
    check("reset err_count", 32'(err_count), 0);
    check("reset pkt_start", 32'(pkt_start), 0);
    check("reset lock_state", 32'(lock_state), 0);
    rst = 1'b0;

    // Reset mid-packet while locked, then re-acquire from HUNT.
    for (int i = 0; i < 3; i++) send_pkt(8'h47, 1'b0, 13'h100, 2'b01, 4'(i), -1);
    check("pre-reset lock_state", 32'(lock_state), 2);
    for (int i = 0; i < 50; i++) send_byte(8'hFF, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("midrst sync", 32'(sync), 0);
    check("midrst lock_state", 32'(lock_state), 0);
    check("midrst pkt_start", 32'(pkt_start), 0);
    check("midrst err_count", 32'(err_count), 0);
    @(posedge clk); #1 rst = 1'b0;
    send_pkt(8'h47, 1'b0, 13'h100, 2'b01, 4'd0, -1);
    check("reacq lock_state", 32'(lock_state), 1);
    check("reacq sync", 32'(sync), 0);

    do_reset();
    run_table("gapless");

    // Saturation, then clear coincident with a TEI error at byte 3.
    for (int i = 0; i < 260; i++) send_pkt(8'h47, 1'b1, 13'h200, 2'b01, 4'd0, -1);
    check("saturated err_count", 32'(err_count), 255);
    check("saturated lock_state", 32'(lock_state), 2);
    send_pkt(8'h47, 1'b1, 13'h200, 2'b01, 4'd0, 3);
    check("clear vs inc err_count", 32'(err_count), 0);
    check("clear keeps lock", 32'(lock_state), 2);
    send_pkt(8'h47, 1'b1, 13'h200, 2'b01, 4'd0, -1);
    check("after clear err_count", 32'(err_count), 1);

    do_reset();
    gap_mode = 1'b1;
    run_table("gapped");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
